mips_pipeline_core: RTL and testbench

- 32-bit MIPS-I integer subset core, 3-stage pipeline: Fetch, Execute, Writeback.
- Top-level compute block: drives a 16-bit instruction address, and receives a 32-bit instruction word in the same cycle.
- Talks to a synchronous data memory.
- Exposes a combinational debug read port into the register file for the testbench.

---
 rtl/mips_pipeline_core.sv | 141 ++++++++++++++
 tb/tb_mips_pipeline_core.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipeline_core.sv
// Three-stage (Fetch / Execute / Writeback) MIPS-I integer core with one branch delay slot.
// Branches resolve in Execute while the delay slot is being fetched, so no flush is ever needed.
module mips_pipeline_core #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] InstrMem,
    output logic [15:0] InstrAddr,
    input  logic [31:0] MemData,
    output logic [31:0] WriteData,
    output logic [15:0] MemAddr,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [4:0]  RegAddr,
    output logic [31:0] RegData
);
    logic [15:0] pc, fe_pc;
    logic [31:0] fe_instr;
    logic [31:0] regs [32];

    logic        ew_we, ew_load;
    logic [4:0]  ew_dst;
    logic [31:0] ew_val;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, dst;
    logic [31:0] imm_s, imm_z, rs_val, rt_val, wb_val, result;
    logic [15:0] pc4, target;
    logic        we, load, mem_rd, mem_wr, taken;

    assign op    = fe_instr[31:26];
    assign rs    = fe_instr[25:21];
    assign rt    = fe_instr[20:16];
    assign rd    = fe_instr[15:11];
    assign shamt = fe_instr[10:6];
    assign funct = fe_instr[5:0];
    assign imm_s = {{16{fe_instr[15]}}, fe_instr[15:0]};
    assign imm_z = {16'h0000, fe_instr[15:0]};
    assign pc4   = fe_pc + 16'd4;

    // W result (load data arrives on MemData during W) bypasses the register file.
    // ew_we is never set for $0, so $0 can never be forwarded.
    assign wb_val = ew_load ? MemData : ew_val;
    assign rs_val = (ew_we && ew_dst == rs) ? wb_val : regs[rs];
    assign rt_val = (ew_we && ew_dst == rt) ? wb_val : regs[rt];

    always_comb begin
        result = '0;
        dst    = rt;
        we     = 1'b0;
        load   = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        taken  = 1'b0;
        target = pc4 + {imm_s[13:0], 2'b00};
        case (op)
            6'h00: begin
                dst = rd;
                we  = 1'b1;
                case (funct)
                    6'h20, 6'h21: result = rs_val + rt_val;
                    6'h22, 6'h23: result = rs_val - rt_val;
                    6'h24: result = rs_val & rt_val;
                    6'h25: result = rs_val | rt_val;
                    6'h26: result = rs_val ^ rt_val;
                    6'h27: result = ~(rs_val | rt_val);
                    6'h2A: result = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B: result = {31'h0, rs_val < rt_val};
                    6'h00: result = rt_val << shamt;
                    6'h02: result = rt_val >> shamt;
                    6'h03: result = $signed(rt_val) >>> shamt;
                    6'h04: result = rt_val << rs_val[4:0];
                    6'h06: result = rt_val >> rs_val[4:0];
                    6'h07: result = $signed(rt_val) >>> rs_val[4:0];
                    6'h08: begin
                        we     = 1'b0;
                        taken  = 1'b1;
                        target = rs_val[15:0];
                    end
                    default: we = 1'b0;
                endcase
            end
            6'h02: begin
                taken  = 1'b1;
                target = {fe_instr[13:0], 2'b00};
            end
            6'h03: begin
                taken  = 1'b1;
                target = {fe_instr[13:0], 2'b00};
                we     = 1'b1;
                dst    = 5'd31;
                result = {16'h0000, fe_pc + 16'd8};
            end
            6'h04: taken = (rs_val == rt_val);
            6'h05: taken = (rs_val != rt_val);
            6'h06: taken = ($signed(rs_val) <= 0);
            6'h07: taken = ($signed(rs_val) > 0);
            6'h08, 6'h09: begin we = 1'b1; result = rs_val + imm_s; end
            6'h0A: begin we = 1'b1; result = {31'h0, $signed(rs_val) < $signed(imm_s)}; end
            6'h0B: begin we = 1'b1; result = {31'h0, rs_val < imm_s}; end
            6'h0C: begin we = 1'b1; result = rs_val & imm_z; end
            6'h0D: begin we = 1'b1; result = rs_val | imm_z; end
            6'h0E: begin we = 1'b1; result = rs_val ^ imm_z; end
            6'h0F: begin we = 1'b1; result = {fe_instr[15:0], 16'h0000}; end
            6'h23: begin we = 1'b1; load = 1'b1; mem_rd = 1'b1; end
            6'h2B: mem_wr = 1'b1;
            default: ;
        endcase
    end

    assign InstrAddr = pc;
    assign MemAddr   = rs_val[15:0] + fe_instr[15:0];
    assign WriteData = rt_val;
    // Strobes are masked during reset so an aborted store never reaches memory.
    assign MemRead   = mem_rd & ~Reset;
    assign MemWrite  = mem_wr & ~Reset;
    assign RegData   = (RegAddr == 5'd0) ? 32'h0 : regs[RegAddr];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc       <= RESET_PC;
            fe_pc    <= RESET_PC;
            fe_instr <= '0;
            ew_we    <= 1'b0;
            ew_load  <= 1'b0;
            ew_dst   <= '0;
            ew_val   <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            pc       <= taken ? target : pc + 16'd4;
            fe_pc    <= pc;
            fe_instr <= InstrMem;
            ew_we    <= we && (dst != 5'd0);
            ew_load  <= load;
            ew_dst   <= dst;
            ew_val   <= result;
            if (ew_we) regs[ew_dst] <= wb_val;
        end
    end
endmodule

// File: tb/tb_mips_pipeline_core.sv
// Bench for mips_pipeline_core: directed programs plus random programs checked cycle by cycle
// against an instruction-level MIPS interpreter (pc/npc delay-slot model).
module tb_mips_pipeline_core;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] InstrMem, MemData, WriteData, RegData;
    logic [15:0] InstrAddr, MemAddr;
    logic        MemWrite, MemRead;
    logic [4:0]  RegAddr = '0;

    logic [31:0] imem [256];
    logic [31:0] dmem [64];
    logic        clr_mem = 1'b1;
    int          n_chk = 0;
    int          n_pass = 0;

    localparam logic [5:0] RFN [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                        6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

    // reference model state
    logic [31:0] m_regs [32];
    logic [31:0] m_mem [64];
    logic [31:0] h0 [32], h1 [32], h2 [32];
    logic [15:0] m_pc, m_npc, e_addr;
    logic        e_mw, e_mr;
    logic [31:0] e_wd;
    logic [15:0] pc_trace [$];
    logic        sw_seen;
    logic [15:0] sw_addr;
    logic [31:0] sw_data;

    mips_pipeline_core #(.RESET_PC(16'h0000)) dut (
        .Clock(Clock), .Reset(Reset), .InstrMem(InstrMem), .InstrAddr(InstrAddr),
        .MemData(MemData), .WriteData(WriteData), .MemAddr(MemAddr),
        .MemWrite(MemWrite), .MemRead(MemRead), .RegAddr(RegAddr), .RegData(RegData)
    );

    always #50 Clock = ~Clock;

    assign InstrMem = imem[InstrAddr[9:2]];

    always @(posedge Clock) begin
        if (clr_mem) begin
            for (int i = 0; i < 64; i++) dmem[i] <= '0;
            MemData <= '0;
        end else begin
            if (MemWrite) dmem[MemAddr[7:2]] <= WriteData;
            if (MemRead) MemData <= dmem[MemAddr[7:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ri(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] ii(input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [5:0]  op;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        sh  = 5'($urandom);
        imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2: begin
                if ($urandom_range(0, 15) == 0) return ri(rs, rt, rd, sh, 6'h3F);
                return ri(rs, rt, rd, sh, RFN[$urandom_range(0, 15)]);
            end
            3, 4, 5: return ii(6'(8 + $urandom_range(0, 7)), rs, rt, imm);
            6: begin
                op = ($urandom_range(0, 1) == 0) ? 6'h23 : 6'h2B;
                return ii(op, rs, rt, imm);
            end
            7: begin
                op  = 6'(4 + $urandom_range(0, 3));
                imm = 16'($urandom_range(0, 16)) - 16'd8;
                return ii(op, rs, rt, imm);
            end
            8: begin
                op = 6'($urandom_range(2, 3));
                return {op, 18'h0, 8'($urandom)};
            end
            default: return {6'h3E, 26'($urandom)};
        endcase
    endfunction

    // Execute one instruction architecturally; record the memory activity it should show in E.
    task automatic model_step(input logic [31:0] ins);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, dst;
        logic [31:0] a, b, se, ze, val;
        logic [15:0] nn;
        logic        wr;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        sh = ins[10:6];  fn = ins[5:0];
        a  = m_regs[rs]; b = m_regs[rt];
        se = 32'(int'($signed(ins[15:0])));
        ze = {16'h0, ins[15:0]};
        nn = m_npc + 16'd4;
        wr = 1'b0; dst = rt; val = '0;
        e_mw = 1'b0; e_mr = 1'b0; e_addr = 16'(a + se); e_wd = b;
        case (op)
            6'h00: begin
                dst = rd; wr = 1'b1;
                case (fn)
                    6'h20, 6'h21: val = a + b;
                    6'h22, 6'h23: val = a - b;
                    6'h24: val = a & b;
                    6'h25: val = a | b;
                    6'h26: val = a ^ b;
                    6'h27: val = ~(a | b);
                    6'h2A: val = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                    6'h2B: val = (a < b) ? 32'd1 : 32'd0;
                    6'h00: val = b << sh;
                    6'h02: val = b >> sh;
                    6'h03: val = 32'(int'(b) >>> sh);
                    6'h04: val = b << a[4:0];
                    6'h06: val = b >> a[4:0];
                    6'h07: val = 32'(int'(b) >>> a[4:0]);
                    6'h08: begin wr = 1'b0; nn = a[15:0]; end
                    default: wr = 1'b0;
                endcase
            end
            6'h02: nn = {ins[13:0], 2'b00};
            6'h03: begin nn = {ins[13:0], 2'b00}; dst = 5'd31; wr = 1'b1; val = {16'h0, m_pc + 16'd8}; end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                if ((op == 6'h04 && a == b) || (op == 6'h05 && a != b) ||
                    (op == 6'h06 && int'(a) <= 0) || (op == 6'h07 && int'(a) > 0))
                    nn = 16'(int'(m_pc) + 4 + 4 * int'($signed(ins[15:0])));
            end
            6'h08, 6'h09: begin wr = 1'b1; val = a + se; end
            6'h0A: begin wr = 1'b1; val = (int'(a) < int'(se)) ? 32'd1 : 32'd0; end
            6'h0B: begin wr = 1'b1; val = (a < se) ? 32'd1 : 32'd0; end
            6'h0C: begin wr = 1'b1; val = a & ze; end
            6'h0D: begin wr = 1'b1; val = a | ze; end
            6'h0E: begin wr = 1'b1; val = a ^ ze; end
            6'h0F: begin wr = 1'b1; val = ze * 32'h10000; end
            6'h23: begin wr = 1'b1; e_mr = 1'b1; val = m_mem[e_addr[7:2]]; end
            6'h2B: begin e_mw = 1'b1; m_mem[e_addr[7:2]] = b; end
            default: ;
        endcase
        if (wr && dst != 5'd0) m_regs[dst] = val;
        m_pc  = m_npc;
        m_npc = nn;
    endtask

    task automatic do_reset();
        Reset = 1'b1; clr_mem = 1'b1;
        #1;
        chk("rst_memread", 32'(MemRead), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        repeat (5) begin
            @(posedge Clock); @(negedge Clock);
            chk("rst_memread", 32'(MemRead), 32'd0);
            chk("rst_memwrite", 32'(MemWrite), 32'd0);
            chk("rst_pc", 32'(InstrAddr), 32'h0);
        end
        for (int a = 0; a < 32; a++) begin
            RegAddr = 5'(a); #1;
            chk("rst_reg", RegData, 32'h0);
        end
        Reset = 1'b0; clr_mem = 1'b0;
        m_pc = 16'h0; m_npc = 16'h4; e_mw = 1'b0; e_mr = 1'b0;
        for (int i = 0; i < 32; i++) begin m_regs[i] = '0; h0[i] = '0; h1[i] = '0; h2[i] = '0; end
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        pc_trace.delete();
        sw_seen = 1'b0;
    endtask

    // One iteration per cycle, sampled mid-cycle: F holds instr c, E holds c-1,
    // and the register file reflects instructions 0..c-3.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            pc_trace.push_back(InstrAddr);
            chk("pc", 32'(InstrAddr), 32'(m_pc));
            chk("memwrite", 32'(MemWrite), 32'(e_mw));
            chk("memread", 32'(MemRead), 32'(e_mr));
            if (e_mw) begin
                chk("st_addr", 32'(MemAddr), 32'(e_addr));
                chk("st_data", WriteData, e_wd);
            end
            if (e_mr) chk("ld_addr", 32'(MemAddr), 32'(e_addr));
            if (MemWrite && !sw_seen) begin sw_seen = 1'b1; sw_addr = MemAddr; sw_data = WriteData; end
            h2 = h1; h1 = h0; h0 = m_regs;
            RegAddr = 5'($urandom_range(0, 31)); #1;
            chk("regdata", RegData, h2[RegAddr]);
            model_step(imem[m_pc[9:2]]);
            @(negedge Clock);
        end
    endtask

    task automatic reg_is(input string tag, input logic [4:0] a, input logic [31:0] exp);
        RegAddr = a; #1;
        chk(tag, RegData, exp);
    endtask

    initial begin
        int exp_pc [12];
        exp_pc = '{0, 4, 8, 12, 16, 20, 28, 32, 36, 40, 44, 40};

        // forwarding, BEQ delay slot, JAL/JR
        for (int i = 0; i < 256; i++) imem[i] = '0;
        imem[0]  = ii(6'h09, 0, 1, 16'd5);
        imem[1]  = ii(6'h09, 1, 2, 16'hFFF9);
        imem[2]  = ri(1, 2, 3, 0, 6'h23);
        imem[4]  = ii(6'h04, 0, 0, 16'd2);
        imem[5]  = ii(6'h09, 0, 7, 16'd1);
        imem[6]  = ii(6'h09, 0, 8, 16'd1);
        imem[8]  = {6'h03, 26'd10};
        imem[10] = ri(31, 0, 0, 0, 6'h08);
        imem[11] = ii(6'h09, 9, 9, 16'd1);
        do_reset();
        run(40);
        for (int i = 0; i < 12; i++) chk("a_pc_seq", 32'(pc_trace[i]), 32'(exp_pc[i]));
        reg_is("a_r1", 1, 32'd5);
        reg_is("a_r2", 2, 32'hFFFFFFFE);
        reg_is("a_r3", 3, 32'd7);
        reg_is("a_r7_slot", 7, 32'd1);
        reg_is("a_r8_skip", 8, 32'd0);
        reg_is("a_r31", 31, 32'd40);

        // LUI/ORI, store/load with load-use forwarding, shifts, compares, $0
        for (int i = 0; i < 256; i++) imem[i] = '0;
        imem[0]  = ii(6'h0F, 0, 4, 16'h1234);
        imem[1]  = ii(6'h0D, 4, 4, 16'h5678);
        imem[2]  = ii(6'h2B, 0, 4, 16'd8);
        imem[3]  = ii(6'h23, 0, 5, 16'd8);
        imem[4]  = ri(5, 5, 6, 0, 6'h21);
        imem[5]  = ii(6'h0F, 0, 10, 16'h8000);
        imem[6]  = ri(0, 10, 11, 4, 6'h03);
        imem[7]  = ii(6'h09, 0, 12, 16'hFFFF);
        imem[8]  = ii(6'h09, 0, 13, 16'd1);
        imem[9]  = ri(12, 13, 14, 0, 6'h2A);
        imem[10] = ri(12, 13, 15, 0, 6'h2B);
        imem[11] = ii(6'h09, 0, 0, 16'd9);
        imem[12] = {6'h02, 26'd12};
        do_reset();
        run(40);
        chk("b_sw_addr", 32'(sw_addr), 32'd8);
        chk("b_sw_data", sw_data, 32'h12345678);
        reg_is("b_r4", 4, 32'h12345678);
        reg_is("b_r5", 5, 32'h12345678);
        reg_is("b_r6", 6, 32'h2468ACF0);
        reg_is("b_sra", 11, 32'hF8000000);
        reg_is("b_slt", 14, 32'd1);
        reg_is("b_sltu", 15, 32'd0);
        reg_is("b_r0", 0, 32'd0);

        // random programs; each new reset lands mid-program
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 256; i++) imem[i] = rand_instr();
            do_reset();
            run(400);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
